// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
//
// Shares one single-port 16-bit block RAM between the CPU (port 0) and a
// secondary master (port 1). At most one access is issued per clock. The RAM
// strobes are driven from registers. Read data comes back exactly two cycles
// after the grant. Port 0 has priority. Port 1 wins once it has been denied
// STARVE_LIMIT consecutive cycles. Addresses above MEM_TOP are rejected with an
// error pulse and never reach the RAM.
//
// Ports
//   clk, rst            system clock; synchronous active-high reset
//   pN_req/we/addr/wdata  request and command from port N (held until gnt)
//   pN_gnt              combinational grant, request accepted this cycle
//   pN_rvalid/rdata     read response pulse and data (two cycles after gnt)
//   pN_err              out-of-range pulse, same timing as rvalid
//   bram_addr/data_in   registered RAM address and write data
//   bram_cs_n/wr_n/rd_n registered active-low RAM strobes
//   bram_data_out       RAM read data, valid one clock after the strobes
// ---------------------------------------------------------------------------
module bram_arbiter #(
  parameter logic [15:0] MEM_TOP      = 16'hEFFF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [15:0] p0_rdata,
  output logic        p0_err,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [15:0] p1_rdata,
  output logic        p1_err,

  output logic [15:0] bram_addr,
  output logic        bram_cs_n,
  output logic        bram_wr_n,
  output logic        bram_rd_n,
  output logic [15:0] bram_data_in,
  input  logic [15:0] bram_data_out
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  // Bookkeeping that travels with each issued access through S1 and S2.
  typedef struct packed {
    logic valid;
    logic port;     // 0 = CPU, 1 = secondary master
    logic is_read;
    logic oor;      // address above MEM_TOP
  } tag_t;

  logic [7:0]  starve_cnt;
  logic        any_gnt;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_oor;
  tag_t        s1_tag;
  tag_t        s2_tag;
  logic        resp_read;
  logic        resp_err;

  // -------------------------------------------------------------------------
  // Grant: port 0 by default, port 1 when alone or when it has starved.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a signal unassigned and infer a latch.
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (p1_req && (!p0_req || starve_cnt == STARVE_MAX)) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end
    end
  end

  assign any_gnt   = p0_gnt | p1_gnt;
  assign sel_we    = p1_gnt ? p1_we    : p0_we;
  assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
  assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
  assign sel_oor   = sel_addr > MEM_TOP;

  // -------------------------------------------------------------------------
  // Starvation counter: counts consecutive denied cycles of port 1.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (!p1_req || p1_gnt) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // S1 issue stage: RAM strobes, address, write data and the access tag.
  // Address and write data hold when nothing in range is issued.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_cs_n    <= 1'b1;
      bram_wr_n    <= 1'b1;
      bram_rd_n    <= 1'b1;
      bram_addr    <= 16'h0000;
      bram_data_in <= 16'h0000;
      s1_tag       <= '0;
    end else begin
      bram_cs_n <= 1'b1;
      bram_wr_n <= 1'b1;
      bram_rd_n <= 1'b1;
      s1_tag    <= '{valid: any_gnt, port: p1_gnt, is_read: !sel_we, oor: sel_oor};
      if (any_gnt && !sel_oor) begin
        bram_cs_n <= 1'b0;
        bram_addr <= sel_addr;
        if (sel_we) begin
          bram_wr_n    <= 1'b0;
          bram_data_in <= sel_wdata;
        end else begin
          bram_rd_n <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // S2 response stage: the tag lines up with bram_data_out from the RAM.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_tag <= '0;
    end else begin
      s2_tag <= s1_tag;
    end
  end

  // Responses are gated by rst so nothing leaks out during the reset cycle.
  assign resp_read = !rst && s2_tag.valid && s2_tag.is_read;
  assign resp_err  = !rst && s2_tag.valid && s2_tag.oor;

  assign p0_rvalid = resp_read && !s2_tag.port;
  assign p1_rvalid = resp_read &&  s2_tag.port;
  assign p0_err    = resp_err  && !s2_tag.port;
  assign p1_err    = resp_err  &&  s2_tag.port;

  // One shared data mux; out-of-range reads return zero.
  assign p0_rdata = s2_tag.oor ? 16'h0000 : bram_data_out;
  assign p1_rdata = p0_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
//
// Directed bench for bram_arbiter with a behavioural single-port RAM model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] bram_addr, bram_data_in;
  logic        bram_cs_n, bram_wr_n, bram_rd_n;
  logic [15:0] bram_data_out = 16'h0000;

  logic [15:0] mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req       (p0_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_gnt       (p0_gnt),
    .p0_rvalid    (p0_rvalid),
    .p0_rdata     (p0_rdata),
    .p0_err       (p0_err),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_gnt       (p1_gnt),
    .p1_rvalid    (p1_rvalid),
    .p1_rdata     (p1_rdata),
    .p1_err       (p1_err),
    .bram_addr    (bram_addr),
    .bram_cs_n    (bram_cs_n),
    .bram_wr_n    (bram_wr_n),
    .bram_rd_n    (bram_rd_n),
    .bram_data_in (bram_data_in),
    .bram_data_out(bram_data_out)
  );

  // Single-port RAM: samples strobes on the rising edge, data one clock later.
  always @(posedge clk) begin
    if (bram_cs_n === 1'b0) begin
      if (bram_wr_n === 1'b0) mem[bram_addr] <= bram_data_in;
      if (bram_rd_n === 1'b0) bram_data_out <= mem[bram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 16'h0000; p0_wdata = 16'h0000;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 16'h0000; p1_wdata = 16'h0000;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  end

  initial begin
    // ---------------- reset with both ports requesting ----------------
    idle();
    rst = 1'b1;
    p0_req = 1'b1;
    p1_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      mid();
      check("rst_p0_gnt", p0_gnt, 0);
      check("rst_p1_gnt", p1_gnt, 0);
      check("rst_cs_n", bram_cs_n, 1);
      check("rst_wr_n", bram_wr_n, 1);
      check("rst_rd_n", bram_rd_n, 1);
      check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    end
    step();
    rst = 1'b0;
    idle();
    mid();
    check("post_rst_cs_n", bram_cs_n, 1);
    check("post_rst_rvalid", {p0_rvalid, p1_rvalid}, 0);

    // ---------------- single port write then read ----------------
    step();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 16'hBEEF;
    mid();
    check("wr_p0_gnt", p0_gnt, 1);
    check("wr_p1_gnt", p1_gnt, 0);
    step();
    p0_we = 1'b0;
    mid();
    check("rd_p0_gnt", p0_gnt, 1);
    check("wr_strobe", {bram_cs_n, bram_wr_n, bram_rd_n}, 3'b001);
    check("wr_addr", bram_addr, 16'h0010);
    check("wr_data", bram_data_in, 16'hBEEF);
    step();
    idle();
    mid();
    check("rd_strobe", {bram_cs_n, bram_wr_n, bram_rd_n}, 3'b010);
    check("rd_addr", bram_addr, 16'h0010);
    check("wr_no_resp", p0_rvalid, 0);
    step();
    mid();
    check("rd_rvalid", p0_rvalid, 1);
    check("rd_rdata", p0_rdata, 16'hBEEF);
    check("rd_err", p0_err, 0);

    // ---------------- contention, starvation limit 4 ----------------
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        p0_req = 1'b1; p0_addr = 16'h0010;
        p1_req = 1'b1; p1_addr = 16'h0020;
      end
      mid();
      check($sformatf("cont_p0_gnt_%0d", i), p0_gnt, (i % 5) != 4);
      check($sformatf("cont_p1_gnt_%0d", i), p1_gnt, (i % 5) == 4);
    end
    step();
    idle();
    step();
    step();

    // ---------------- out-of-range read ----------------
    p1_req = 1'b1; p1_addr = 16'hF000;
    mid();
    check("oor_rd_gnt", p1_gnt, 1);
    step();
    idle();
    mid();
    check("oor_rd_strobe", {bram_cs_n, bram_wr_n, bram_rd_n}, 3'b111);
    step();
    mid();
    check("oor_rd_rvalid", p1_rvalid, 1);
    check("oor_rd_err", p1_err, 1);
    check("oor_rd_rdata", p1_rdata, 16'h0000);
    check("oor_rd_p0", {p0_rvalid, p0_err}, 0);

    // ---------------- out-of-range write ----------------
    step();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'hFFFF; p1_wdata = 16'h1234;
    mid();
    check("oor_wr_gnt", p1_gnt, 1);
    step();
    idle();
    mid();
    check("oor_wr_strobe", {bram_cs_n, bram_wr_n, bram_rd_n}, 3'b111);
    check("oor_wr_addr_hold", bram_addr, 16'h0020);
    step();
    mid();
    check("oor_wr_err", p1_err, 1);
    check("oor_wr_rvalid", p1_rvalid, 0);
    check("oor_wr_mem", mem[16'hFFFF], 16'h0000);

    // ---------------- top in-range address ----------------
    step();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'hEFFF; p0_wdata = 16'h5A5A;
    mid();
    check("top_gnt", p0_gnt, 1);
    step();
    idle();
    mid();
    check("top_strobe", {bram_cs_n, bram_wr_n, bram_rd_n}, 3'b001);
    check("top_addr", bram_addr, 16'hEFFF);
    step();
    mid();
    check("top_err", p0_err, 0);
    check("top_mem", mem[16'hEFFF], 16'h5A5A);

    // ---------------- interleaved reads ----------------
    step();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0001; p0_wdata = 16'h1111;
    mid();
    check("pre1_gnt", p0_gnt, 1);
    step();
    p0_addr = 16'h0002; p0_wdata = 16'h2222;
    mid();
    check("pre2_gnt", p0_gnt, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      idle();
      if (k < 6) begin
        if (k % 2 == 0) begin
          p0_req = 1'b1; p0_addr = 16'h0001;
        end else begin
          p1_req = 1'b1; p1_addr = 16'h0002;
        end
      end
      mid();
      if (k < 6) begin
        check($sformatf("il_gnt_%0d", k), {p0_gnt, p1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (k >= 2) begin
        if ((k - 2) % 2 == 0) begin
          check($sformatf("il_rv_%0d", k), {p0_rvalid, p1_rvalid}, 2'b10);
          check($sformatf("il_rd_%0d", k), p0_rdata, 16'h1111);
        end else begin
          check($sformatf("il_rv_%0d", k), {p0_rvalid, p1_rvalid}, 2'b01);
          check($sformatf("il_rd_%0d", k), p1_rdata, 16'h2222);
        end
      end
    end

    // ---------------- reset mid-flight ----------------
    step();
    idle();
    p0_req = 1'b1; p0_addr = 16'h0010;
    mid();
    check("mf_gnt", p0_gnt, 1);
    step();
    idle();
    rst = 1'b1;
    mid();
    check("mf_rst_gnt", p0_gnt, 0);
    step();
    rst = 1'b0;
    mid();
    check("mf_rvalid_1", {p0_rvalid, p0_err}, 0);
    check("mf_cs_n", bram_cs_n, 1);
    step();
    mid();
    check("mf_rvalid_2", {p0_rvalid, p0_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port arbiter that shares the single-port 16-bit block RAM between the CPU (port 0) and a secondary master such as DMA or video fetch (port 1). Issues at most one access per clock, drives the RAM's active-low chip-select/write/read strobes from registers, and returns read data with fixed latency. Port 0 has priority, bounded by a starvation limit for port 1. Addresses above the implemented RAM top are rejected without touching the RAM.

## Interface
- MEM_TOP, 16'hEFFF: highest implemented word address; an address above it is out of range.
- STARVE_LIMIT, 4: consecutive denied cycles after which port 1 wins; legal range 1..255.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req / p1_req  in  1  access request; held with its command until granted.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  16  word address.
- p0_wdata / p1_wdata  in  16  write data.
- p0_gnt / p1_gnt  out  1  combinational; request accepted this cycle.
- p0_rvalid / p1_rvalid  out  1  read data valid this cycle (one-cycle pulse).
- p0_rdata / p1_rdata  out  16  read data; meaningful only with rvalid.
- p0_err / p1_err  out  1  one-cycle pulse, aligned with rvalid timing, for an out-of-range access.
- bram_addr  out  16  registered RAM address.
- bram_cs_n, bram_wr_n, bram_rd_n  out  1  registered active-low RAM strobes.
- bram_data_in  out  16  registered RAM write data.
- bram_data_out  in  16  RAM read data, valid one clock after the strobes are sampled.

## Operation
- Grant logic, combinational, evaluated every cycle with rst low:
  - If only one port requests, it wins.
  - If both request, port 0 wins unless starve_cnt == STARVE_LIMIT; then port 1 wins.
  - Exactly one gnt is high when any req is high; none when rst is high.
- starve_cnt, 8-bit:
  - Increments when p1_req=1 and p1_gnt=0, saturating at STARVE_LIMIT.
  - Clears when p1_gnt=1 or p1_req=0.
- Issue stage (S1 registers), loaded on the clock edge ending the grant cycle:
  - In-range read: cs_n=0, rd_n=0, wr_n=1, bram_addr = granted address.
  - In-range write: cs_n=0, wr_n=0, rd_n=1, bram_data_in = granted wdata.
  - Out-of-range access (address > MEM_TOP): cs_n=1, wr_n=1, rd_n=1. No RAM access occurs.
  - No grant: cs_n=1, wr_n=1, rd_n=1; bram_addr and bram_data_in hold their previous values.
  - A tag {valid, port, is_read, oor} is stored alongside.
- Response stage (S2): the tag advances one more stage.
  - Read tag: rvalid pulses for the tagged port; rdata = bram_data_out.
  - Out-of-range tag: err pulses for the tagged port. For an out-of-range read, rvalid also pulses with rdata = 16'h0000.
  - In-range write: no response.
- Both pN_rdata outputs are driven from the same S2 mux; a port ignores rdata unless its rvalid is high.
- Reset values: bram_cs_n, bram_wr_n and bram_rd_n = 1; bram_addr and bram_data_in = 0; all gnt, rvalid and err = 0; starve_cnt = 0; S1 and S2 tags invalid.

## Timing
- Grant in cycle t → strobes visible in t+1 → RAM samples at the end of t+1 → rvalid/rdata/err in cycle t+2. Read latency is exactly 2 cycles from gnt.
- Throughput is one access per cycle. Back-to-back grants, mixed ports and mixed read/write are fully pipelined with no bubbles.
- Write followed by a read to the same address on consecutive grants returns the new data. The write is sampled at t+1 and the read at t+2, so no forwarding is needed.
- Requester rule: req, we, addr and wdata stay stable from assertion until the cycle in which gnt is high. req may drop or change in the cycle after gnt.
- Reset mid-operation: any in-flight S1/S2 access is discarded. No rvalid or err follows the reset cycle. Strobes are inactive from the first cycle after rst is sampled high.

## Test plan
- Reset: hold rst 2 cycles with both req=1 → all gnt=0, cs_n, wr_n and rd_n = 1, no rvalid, for the whole reset and 1 cycle after.
- Single port: p0 writes 16'hBEEF to 0x0010, then reads 0x0010 on the next cycle → p0_rvalid exactly 2 cycles after the read gnt, with p0_rdata = 16'hBEEF.
- Contention, STARVE_LIMIT=4: both ports request continuously → grant pattern 0,0,0,0,1 repeating; p1 never waits more than 4 cycles.
- Out of range: p1 reads 0xF000 → RAM strobes stay inactive; 2 cycles later p1_rvalid=1, p1_err=1, p1_rdata=0. A write to 0xFFFF gives p1_err only and leaves RAM contents unchanged.
- Interleave: alternating p0/p1 reads of preloaded 0x0001=16'h1111 and 0x0002=16'h2222 every cycle → correct data routed to the correct port each cycle, with no bubbles.
- Reset mid-flight: assert rst in the cycle after a read grant → no rvalid appears afterwards.
